// File: rtl/mlp_pkg.sv
// Shared fixed-point formats and constants for the MLP datapath.
package mlp_pkg;

  localparam int Q_IN_W     = 19;
  localparam int Q_IN_INT   = 10;
  localparam int Q_OUT_W    = 8;
  localparam int Q_OUT_INT  = 3;
  localparam int Q_OUT_FRAC = 4;

  typedef logic signed [Q_IN_W-1:0]  q_in_t;
  typedef logic signed [Q_OUT_W-1:0] q_out_t;

  localparam q_out_t Q_OUT_MAX = 8'h7F;
  localparam q_out_t Q_OUT_MIN = 8'h80;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/sat_requant.sv
// Combinational saturating requantizer: signed Q(INT_LENGTH).(frac) -> signed Q3.4,
// fraction truncated toward minus infinity.
module sat_requant
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = Q_IN_W,
  parameter int INT_LENGTH = Q_IN_INT
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [Q_OUT_W-1:0]    y,
  output logic                  sat
);

  localparam int FRAC = DATA_WIDTH - 1 - INT_LENGTH;
  localparam int UW   = INT_LENGTH - Q_OUT_INT;

  logic          s;
  logic [UW-1:0] u;
  logic          unused_low;

  assign s = x[DATA_WIDTH-1];
  // Integer bits that do not fit in Q3.4 must all be copies of the sign.
  assign u = x[DATA_WIDTH-2 -: UW];
  assign unused_low = ^x[FRAC-Q_OUT_FRAC-1:0];

  always_comb begin
    sat = (u != {UW{s}});
    y   = {s, x[FRAC+Q_OUT_INT-1 -: Q_OUT_W-1]};
    if (sat) begin
      y = s ? Q_OUT_MIN : Q_OUT_MAX;
    end
  end

endmodule

// File: rtl/requant_arbiter.sv
// Round-robin share of one requantizer between two neuron accumulators, with a
// registered valid/ready result and per-neuron saturation event counters.
module requant_arbiter
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int INT_LENGTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            in_valid,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  output logic [1:0]            in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_id,
  output logic                  out_sat,
  input  logic                  out_ready,
  input  logic                  sat_clr,
  output logic [CNT_WIDTH-1:0]  sat_cnt0,
  output logic [CNT_WIDTH-1:0]  sat_cnt1
);

  res_state_e             state_q;
  logic [7:0]             data_q;
  logic                   id_q;
  logic                   sat_q;
  logic                   last_grant_q;
  logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]   cnt1_q, cnt1_d;

  logic [1:0]             grant;
  logic                   can_load;
  logic                   sel_id;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [7:0]             rq_data;
  logic                   rq_sat;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_sat   = sat_q;
  assign sat_cnt0  = cnt0_q;
  assign sat_cnt1  = cnt1_q;

  assign can_load = ~out_valid | out_ready;

  always_comb begin
    grant = '0;
    case (in_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign in_ready = grant & {2{can_load}};
  assign xfer     = |(in_valid & in_ready);
  assign sel_id   = grant[1];
  assign sel_data = sel_id ? in_data1 : in_data0;

  sat_requant #(
    .DATA_WIDTH (DATA_WIDTH),
    .INT_LENGTH (INT_LENGTH)
  ) u_requant (
    .x   (sel_data),
    .y   (rq_data),
    .sat (rq_sat)
  );

  // Counters stick at all-ones; a same-cycle clear beats the increment.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (sat_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (xfer && rq_sat) begin
      if (!sel_id && cnt0_q != '1) cnt0_d = cnt0_q + CNT_WIDTH'(1);
      if (sel_id && cnt1_q != '1)  cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      sat_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      if (xfer) begin
        data_q       <= rq_data;
        id_q         <= sel_id;
        sat_q        <= rq_sat;
        last_grant_q <= sel_id;
      end
      case (state_q)
        ST_EMPTY: if (xfer) state_q <= ST_FULL;
        ST_FULL:  if (out_ready && !xfer) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_requant_arbiter.sv
// Scoreboard bench for requant_arbiter: a reference model predicts grants and
// results from the arithmetic definition; a monitor compares what the DUT emits.
module tb_requant_arbiter;

  localparam int DW = 19;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    in_valid;
  logic [DW-1:0] in_data0, in_data1;
  logic [1:0]    in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_id, out_sat;
  logic          out_ready, sat_clr;
  logic [CW-1:0] sat_cnt0, sat_cnt1;

  requant_arbiter #(
    .DATA_WIDTH (DW),
    .INT_LENGTH (10),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_cnt0  (sat_cnt0),
    .sat_cnt1  (sat_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit   m_full;
  int   m_last;
  int   m_cnt[2];

  localparam logic [DW-1:0] T1   = 19'b000_0000_0111_1100_0011;
  localparam logic [DW-1:0] T2A  = 19'b000_0000_1111_1100_0011;
  localparam logic [DW-1:0] T2B  = 19'b100_0000_0001_1101_0111;
  localparam logic [DW-1:0] T3   = 19'b111_1111_1010_1100_0011;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Value/16 rounded toward minus infinity, clamped to the Q3.4 range.
  function automatic void requant_ref(input logic [DW-1:0] x, output int q, output int s);
    int v;
    v = $signed(x);
    q = v >>> 4;
    s = 0;
    if (q > 127) begin
      q = 127;
      s = 1;
    end else if (q < -128) begin
      q = -128;
      s = 1;
    end
  endfunction

  function automatic logic [DW-1:0] rnd_x();
    int t;
    if ($urandom_range(0, 1) == 0) begin
      t = int'($urandom_range(0, 4095)) - 2048;
      return t[DW-1:0];
    end
    t = int'($urandom);
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    sb.delete();
    m_full = 1'b0;
    m_last = 1;
    m_cnt  = '{0, 0};
  endtask

  // Monitor: compares the presented result against the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("out_id", int'(out_id), sb[0].id);
          check("out_data", int'($signed(out_data)), sb[0].data);
          check("out_sat", int'(out_sat), sb[0].sat);
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check("lost_result", sb.size(), 0);
      end
      check("sat_cnt0", int'(sat_cnt0), m_cnt[0]);
      check("sat_cnt1", int'(sat_cnt1), m_cnt[1]);
    end
  end

  // Reference model: predicts acceptance for the coming edge and queues results.
  always @(negedge clk) begin
    int         g, q, s;
    bit         cl;
    logic [1:0] er;
    #1;
    if (rst_n) begin
      cl = !m_full || out_ready;
      case (in_valid)
        2'b01:   g = 0;
        2'b10:   g = 1;
        2'b11:   g = 1 - m_last;
        default: g = -1;
      endcase
      er = (g >= 0 && cl) ? (2'b01 << g) : 2'b00;
      check("in_ready", int'(in_ready), int'(er));
      if (er != 2'b00) begin
        requant_ref((g == 1) ? in_data1 : in_data0, q, s);
        sb.push_back('{g, q, s});
        m_full = 1'b1;
        m_last = g;
        if (s != 0 && m_cnt[g] < 65535) m_cnt[g]++;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      if (sat_clr) m_cnt = '{0, 0};
    end
  end

  task automatic drive(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data0  = d0;
    in_data1  = d1;
    out_ready = ordy;
    sat_clr   = clr;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data0  = '0;
    in_data1  = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_id", int'(out_id), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_sat_cnt0", int'(sat_cnt0), 0);
    check("rst_sat_cnt1", int'(sat_cnt1), 0);
    rst_n = 1'b1;

    drive(2'b01, T1, '0, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    drive(2'b10, '0, T2A, 1'b1, 1'b0);
    drive(2'b10, '0, T2B, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);

    repeat (4) drive(2'b11, T3, rnd_x(), 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);

    drive(2'b01, T1, '0, 1'b1, 1'b0);
    repeat (3) drive(2'b11, T3, T2A, 1'b0, 1'b0);
    drive(2'b11, T3, T2A, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);

    drive(2'b00, '0, '0, 1'b1, 1'b1);
    repeat (65536) drive(2'b01, T2A, '0, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("cnt0_stuck", int'(sat_cnt0), 65535);
    drive(2'b01, T2B, '0, 1'b1, 1'b1);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("cnt0_cleared", int'(sat_cnt0), 0);

    repeat (1500) begin
      drive(2'($urandom_range(0, 3)), rnd_x(), rnd_x(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);

    drive(2'b01, T2A, '0, 1'b0, 1'b0);
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_sat_cnt0", int'(sat_cnt0), 0);
    check("arst_sat_cnt1", int'(sat_cnt1), 0);
    #4;
    rst_n = 1'b1;
    drive(2'b11, T3, T1, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    #2;
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_id", int'(out_id), 0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
